packetizer_rr: RTL and testbench



---
 rtl/packetizer_rr.sv | 163 ++++++++++++++++
 tb/tb_packetizer_rr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_rr.sv
// Multi-channel packetizer: round-robin arbitration into a shared FIFO, then each entry is
// serialized onto the L2 link as one header flit followed by N_PKTS data flits.
module packetizer_rr #(
    parameter int unsigned N_CH               = 2,
    parameter int unsigned CH_BITS            = 1,
    parameter int unsigned PAYLOAD_WIDTH      = 128,
    parameter int unsigned PACKET_WIDTH       = 16,
    parameter int unsigned DEPTH              = 4,
    parameter int unsigned DEPTH_LOG          = 2,
    parameter int unsigned PUSH_AF_LVL        = 1,
    parameter int unsigned N_PKTS_BITS        = 4,
    parameter int unsigned THROTTLE           = 0,
    parameter int unsigned THROTTLE_THRESHOLD = 2,
    parameter int unsigned OUT_BITS           = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CH-1:0]               payload_req_i,
    input  logic [N_CH*PAYLOAD_WIDTH-1:0] payload_i,
    output logic [N_CH-1:0]               payload_grant_o,
    output logic                          fifo_af_o,
    output logic                          packet_req_o,
    output logic                          lock_o,
    output logic [PACKET_WIDTH-1:0]       packet_o,
    input  logic                          packet_grant_i,
    input  logic                          packet_received_i,
    output logic [OUT_BITS-1:0]           outstanding_o
);

    localparam int unsigned N_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;

    if (PACKET_WIDTH < 1 + N_PKTS_BITS + CH_BITS) begin : g_bad_header_width
        $fatal(1, "packetizer_rr: PACKET_WIDTH too narrow for header fields");
    end

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                   state_q, state_d;
    logic [PAYLOAD_WIDTH-1:0] mem_payload_q [DEPTH];
    logic [CH_BITS-1:0]       mem_id_q [DEPTH];
    logic [DEPTH_LOG-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG:0]       count_q, count_d;
    logic [CH_BITS-1:0]       rr_ptr_q, grant_id;
    logic [PAYLOAD_WIDTH-1:0] grant_payload, head_payload;
    logic [CH_BITS-1:0]       head_id;
    logic [N_PKTS_BITS-1:0]   cnt_q, cnt_d, flit_idx;
    logic [OUT_BITS-1:0]      outstanding_q, outstanding_d;
    logic [PACKET_WIDTH-1:0]  header;
    logic                     push, pop, full, empty, allow;

    assign full      = (count_q == (DEPTH_LOG + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign fifo_af_o = (count_q >= (DEPTH_LOG + 1)'(DEPTH - PUSH_AF_LVL));
    assign head_payload  = mem_payload_q[rd_ptr_q];
    assign head_id       = mem_id_q[rd_ptr_q];
    assign outstanding_o = outstanding_q;

    // Two passes give the rotating priority: channels above the pointer first, then wrap.
    always_comb begin
        payload_grant_o = '0;
        grant_id        = rr_ptr_q;
        grant_payload   = '0;
        push            = 1'b0;
        if (!full) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (!push && payload_req_i[c] && c > 32'(rr_ptr_q)) begin
                    push               = 1'b1;
                    grant_id           = CH_BITS'(c);
                    grant_payload      = payload_i[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                    payload_grant_o[c] = 1'b1;
                end
            end
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (!push && payload_req_i[c] && c <= 32'(rr_ptr_q)) begin
                    push               = 1'b1;
                    grant_id           = CH_BITS'(c);
                    grant_payload      = payload_i[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                    payload_grant_o[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        header                                     = '0;
        header[0]                                  = 1'b1;
        header[N_PKTS_BITS:1]                      = N_PKTS_BITS'(N_PKTS);
        header[N_PKTS_BITS+CH_BITS -: CH_BITS]     = head_id;
    end

    assign flit_idx = N_PKTS_BITS'(N_PKTS) - cnt_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        packet_o     = '0;
        pop          = 1'b0;
        allow        = (THROTTLE == 0) || (outstanding_q < OUT_BITS'(THROTTLE_THRESHOLD));
        packet_req_o = (state_q == StIdle) && !empty && allow;
        lock_o       = packet_req_o || (state_q == StSend);
        unique case (state_q)
            StIdle: begin
                if (packet_req_o && packet_grant_i) begin
                    packet_o = header;
                    cnt_d    = N_PKTS_BITS'(N_PKTS);
                    state_d  = StSend;
                end
            end
            StSend: begin
                packet_o = PACKET_WIDTH'(head_payload >> (32'(flit_idx) * PACKET_WIDTH));
                cnt_d    = cnt_q - N_PKTS_BITS'(1);
                if (cnt_q == N_PKTS_BITS'(1)) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d       = count_q + (DEPTH_LOG + 1)'(push) - (DEPTH_LOG + 1)'(pop);
        outstanding_d = outstanding_q;
        // A completion and a new send in the same cycle cancel out.
        if (pop && !packet_received_i) begin
            if (outstanding_q != '1) outstanding_d = outstanding_q + OUT_BITS'(1);
        end else if (!pop && packet_received_i) begin
            if (outstanding_q != '0) outstanding_d = outstanding_q - OUT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_payload_q[wr_ptr_q] <= grant_payload;
            mem_id_q[wr_ptr_q]      <= grant_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rr_ptr_q      <= CH_BITS'(N_CH - 1);
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            if (push) begin
                rr_ptr_q <= grant_id;
                wr_ptr_q <= (wr_ptr_q == DEPTH_LOG'(DEPTH - 1)) ? '0 : wr_ptr_q + DEPTH_LOG'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == DEPTH_LOG'(DEPTH - 1)) ? '0 : rd_ptr_q + DEPTH_LOG'(1);
            end
        end
    end

endmodule

// File: tb/tb_packetizer_rr.sv
// Directed bench for packetizer_rr: a queue-based model checked every cycle, plus literal
// expectations for headers, flits, grants and throttling.
module tb_packetizer_rr;

    localparam int N_CH     = 2;
    localparam int CH_BITS  = 1;
    localparam int PW       = 128;
    localparam int KW       = 16;
    localparam int DEPTH    = 4;
    localparam int AF_LVL   = 1;
    localparam int NPB      = 4;
    localparam int THR      = 2;
    localparam int OUT_BITS = 4;
    localparam int N_PKTS   = PW / KW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N_CH-1:0]      payload_req_i = '0;
    logic [N_CH*PW-1:0]   payload_i = '0;
    logic [N_CH-1:0]      payload_grant_o;
    logic                 fifo_af_o, packet_req_o, lock_o;
    logic [KW-1:0]        packet_o;
    logic                 packet_grant_i = 1'b0;
    logic                 packet_received_i = 1'b0;
    logic [OUT_BITS-1:0]  outstanding_o;

    packetizer_rr #(
        .N_CH(N_CH), .CH_BITS(CH_BITS), .PAYLOAD_WIDTH(PW), .PACKET_WIDTH(KW),
        .DEPTH(DEPTH), .DEPTH_LOG(2), .PUSH_AF_LVL(AF_LVL), .N_PKTS_BITS(NPB),
        .THROTTLE(1), .THROTTLE_THRESHOLD(THR), .OUT_BITS(OUT_BITS)
    ) dut (
        .clk(clk), .reset(reset),
        .payload_req_i(payload_req_i), .payload_i(payload_i),
        .payload_grant_o(payload_grant_o), .fifo_af_o(fifo_af_o),
        .packet_req_o(packet_req_o), .lock_o(lock_o), .packet_o(packet_o),
        .packet_grant_i(packet_grant_i), .packet_received_i(packet_received_i),
        .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [KW-1:0] hdr(input int id);
        return KW'(1 + (N_PKTS << 1) + (id << (1 + NPB)));
    endfunction

    // Model state: FIFO as queues, burst as "flits remaining", outstanding as an int.
    logic [PW-1:0]   mq_p[$];
    int              mq_id[$];
    int              m_rem = 0;
    int              m_out = 0;
    int              m_rr = N_CH - 1;
    logic [N_CH-1:0] mdl_grant = '0;
    logic [PW-1:0]   chq[N_CH][$];

    always @(negedge clk) begin : cmp
        int gi;
        logic [N_CH-1:0] eg;
        logic er, el, last;
        logic [KW-1:0] ep;
        if (reset) begin
            mq_p.delete();
            mq_id.delete();
            m_rem = 0;
            m_out = 0;
            m_rr = N_CH - 1;
            mdl_grant = '0;
            chk("rst_grant", payload_grant_o, 0);
            chk("rst_af", fifo_af_o, 0);
            chk("rst_req", packet_req_o, 0);
            chk("rst_lock", lock_o, 0);
            chk("rst_pkt", packet_o, 0);
            chk("rst_out", outstanding_o, 0);
        end else begin
            gi = -1;
            if (mq_p.size() < DEPTH) begin
                for (int k = 1; k <= N_CH; k++) begin
                    if (gi < 0 && payload_req_i[(m_rr + k) % N_CH]) gi = (m_rr + k) % N_CH;
                end
            end
            eg = '0;
            if (gi >= 0) eg[gi] = 1'b1;
            if (m_rem == 0) begin
                er = (mq_p.size() > 0) && (m_out < THR);
                el = er;
                ep = (er && packet_grant_i) ? hdr(mq_id[0]) : '0;
            end else begin
                er = 1'b0;
                el = 1'b1;
                ep = KW'(mq_p[0] >> (KW * (N_PKTS - m_rem)));
            end
            chk("grant", payload_grant_o, eg);
            chk("fifo_af", fifo_af_o, mq_p.size() >= DEPTH - AF_LVL);
            chk("packet_req", packet_req_o, er);
            chk("lock", lock_o, el);
            chk("packet", packet_o, ep);
            chk("outstanding", outstanding_o, m_out);
            last = (m_rem == 1);
            if (m_rem == 0) begin
                if (er && packet_grant_i) m_rem = N_PKTS;
            end else begin
                m_rem--;
            end
            if (last) begin
                void'(mq_p.pop_front());
                void'(mq_id.pop_front());
            end
            if (gi >= 0) begin
                mq_p.push_back(payload_i[gi*PW +: PW]);
                mq_id.push_back(gi);
                m_rr = gi;
            end
            if (last && !packet_received_i) begin
                if (m_out < (1 << OUT_BITS) - 1) m_out++;
            end else if (!last && packet_received_i && m_out > 0) begin
                m_out--;
            end
            mdl_grant = eg;
        end
    end

    task automatic drive();
        for (int c = 0; c < N_CH; c++) begin
            payload_req_i[c] = (chq[c].size() > 0);
            payload_i[c*PW +: PW] = (chq[c].size() > 0) ? chq[c][0] : '0;
        end
    endtask

    // One clock: retire granted requests, present the rest, set link inputs.
    task automatic cycle(input logic g, input logic r);
        @(posedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (mdl_grant[c]) void'(chq[c].pop_front());
        end
        drive();
        packet_grant_i = g;
        packet_received_i = r;
    endtask

    logic [N_CH-1:0] exp_g[5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    logic            exp_af[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N_CH-1:0] exp_alt[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // received while nothing outstanding
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        #2 chk("out_stays_zero", outstanding_o, 0);

        // single ch0 burst, link grant pulsing during SEND
        chq[0].push_back(128'h0F0E0D0C0B0A09080706050403020100);
        cycle(1'b0, 1'b0);
        #2 chk("g_ch0", payload_grant_o, 2'b01);
        cycle(1'b1, 1'b0);
        #2 chk("hdr_ch0", packet_o, 16'h0011);
        chk("req_hdr", packet_req_o, 1);
        for (int k = 0; k < N_PKTS; k++) begin
            cycle((k % 2) == 0, 1'b0);
            #2 chk("flit", packet_o, ((2 * k + 1) << 8) | (2 * k));
            chk("req_in_send", packet_req_o, 0);
            chk("lock_in_send", lock_o, 1);
        end
        cycle(1'b0, 1'b0);
        #2 chk("out_after_burst", outstanding_o, 1);
        chk("pkt_idle", packet_o, 0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        #2 chk("out_dec", outstanding_o, 0);

        // fill the FIFO with the link held off
        chq[0].push_back({4{32'hA0A1_0001}});
        chq[0].push_back({4{32'hA0A2_0002}});
        chq[0].push_back({4{32'hA0A3_0003}});
        chq[1].push_back({4{32'hB0B1_0011}});
        chq[1].push_back({4{32'hB0B2_0012}});
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            #2 chk("fill_grant", payload_grant_o, exp_g[i]);
            chk("fill_af", fifo_af_o, exp_af[i]);
        end
        cycle(1'b1, 1'b0);
        #2 chk("hdr_ch1", packet_o, 16'h0031);
        chk("full_no_grant", payload_grant_o, 0);
        for (int k = 0; k < N_PKTS; k++) begin
            cycle(1'b0, 1'b0);
            #2 chk("full_pop_no_grant", payload_grant_o, 0);
        end
        cycle(1'b0, 1'b0);
        #2 chk("grant_resume", payload_grant_o, 2'b01);
        chk("req_after_burst", packet_req_o, 1);

        // throttle: second burst reaches the threshold
        cycle(1'b1, 1'b0);
        #2 chk("hdr_ch0_b", packet_o, 16'h0011);
        repeat (N_PKTS) cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            #2 chk("throttled_req", packet_req_o, 0);
            chk("throttled_out", outstanding_o, 2);
            chk("throttled_lock", lock_o, 0);
        end
        cycle(1'b0, 1'b1);
        #2 chk("req_still_low", packet_req_o, 0);
        cycle(1'b1, 1'b0);
        #2 chk("out_after_rcv", outstanding_o, 1);
        chk("req_reassert", packet_req_o, 1);
        chk("hdr_ch1_b", packet_o, 16'h0031);
        repeat (N_PKTS - 1) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        #2 chk("out_coincident", outstanding_o, 1);

        // reset in the 4th SEND cycle
        cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        packet_grant_i = 1'b0;
        #1 chk("mid_rst_pkt", packet_o, 0);
        chk("mid_rst_lock", lock_o, 0);
        chk("mid_rst_req", packet_req_o, 0);
        chk("mid_rst_out", outstanding_o, 0);
        chk("mid_rst_af", fifo_af_o, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #2 chk("post_rst_req", packet_req_o, 0);
        chk("post_rst_out", outstanding_o, 0);

        // both channels continuously requesting after reset
        chq[0].push_back({8{16'h1234}});
        chq[0].push_back({8{16'h5678}});
        chq[1].push_back({8{16'h9ABC}});
        chq[1].push_back({8{16'hDEF0}});
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0);
            #2 chk("alt_grant", payload_grant_o, exp_alt[i]);
        end
        for (int i = 0; i < 60; i++) cycle(1'b1, (i % 5) == 4);
        cycle(1'b0, 1'b0);
        #2 chk("drained_req", packet_req_o, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
